mod_p_stream_cipher: RTL and testbench

- Downstream consumer of the public-key generator.
- Latches the generated key when the key-ready pulse arrives, then encrypts or decrypts a byte stream character by character using mod-227 arithmetic.
- Input and output streams use valid/ready handshakes. The output has a one-deep register.
- Feeds the UART/display back end.

---
 rtl/cipher_pkg.sv | 29 ++
 rtl/mod_p_addsub.sv | 49 ++++
 rtl/mod_p_stream_cipher.sv | 199 +++++++++++++++++++
 tb/tb_mod_p_stream_cipher.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared constants, state encoding and key-rotation helper for the mod-227
// stream cipher.
package cipher_pkg;

  localparam int unsigned P_MOD     = 32'd227;
  localparam logic [8:0]  P_MOD_9   = 9'd227;
  localparam logic [7:0]  NULL_CHAR = 8'h00;
  localparam logic [1:0]  MODE_ENC  = 2'b00;
  localparam logic [1:0]  MODE_DEC  = 2'b01;

  typedef enum logic [1:0] {
    WAIT_KEY = 2'b00,
    RUN      = 2'b01,
    DRAIN    = 2'b10
  } state_t;

  // Advance a key by one inside 1..P_MOD-1; the top value wraps back to 1 so
  // the key can never become 0 (which would leave characters unchanged).
  function automatic logic [7:0] next_rot_key(input logic [7:0] key);
    logic [7:0] nxt;
    if ({1'b0, key} >= (P_MOD_9 - 9'd1)) begin
      nxt = 8'd1;
    end else begin
      nxt = key + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mod_p_addsub.sv
// Combinational mod-P add (encrypt) / subtract (decrypt) of one character
// against the current key. Characters >= P are flagged and mapped to NULL_CHAR.
module mod_p_addsub
  import cipher_pkg::*;
#(
  parameter int unsigned P_MOD_P = cipher_pkg::P_MOD
) (
  input  logic [7:0] i_data,
  input  logic [7:0] i_key,
  input  logic       i_dec,
  output logic [7:0] o_result,
  output logic       o_invalid
);

  localparam logic [8:0] LP_MOD = 9'(P_MOD_P);

  logic [8:0] w_data9;
  logic [8:0] w_key9;
  logic [8:0] w_sum;

  // Widen operands to 9 bits so the sum and the +P correction cannot overflow.
  always_comb begin
    w_data9 = {1'b0, i_data};
    w_key9  = {1'b0, i_key};
    w_sum   = w_data9 + w_key9;
  end

  // Select the encrypt or decrypt result, forcing NULL_CHAR for illegal input.
  always_comb begin
    o_invalid = (w_data9 >= LP_MOD);
    o_result  = NULL_CHAR;
    if (o_invalid) begin
      o_result = NULL_CHAR;
    end else if (i_dec) begin
      if (w_data9 >= w_key9) begin
        o_result = 8'(w_data9 - w_key9);
      end else begin
        o_result = 8'(w_data9 + LP_MOD - w_key9);
      end
    end else begin
      if (w_sum >= LP_MOD) begin
        o_result = 8'(w_sum - LP_MOD);
      end else begin
        o_result = 8'(w_sum);
      end
    end
  end

endmodule

// File: rtl/mod_p_stream_cipher.sv
// Mod-227 stream cipher: latches a one-shot key from the key generator, then
// encrypts/decrypts a valid/ready character stream into a one-deep output
// register. Build option: define KEY_ROTATE_EN to step the key after every
// accepted character (wrapping 226 -> 1); otherwise the key is constant for
// the whole message.
module mod_p_stream_cipher
  import cipher_pkg::*;
#(
  parameter int unsigned P_MOD = cipher_pkg::P_MOD,
  parameter int unsigned CNT_W = 32'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [7:0]       public_key,
  input  logic             pk_ready,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err_invalid_char,
  output logic             err_invalid_key,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [8:0]       LP_MOD     = 9'(P_MOD);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_key;
  logic [1:0]       r_mode;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_err_char;
  logic             r_err_key;
  logic [CNT_W-1:0] r_byte_count;

  logic             w_key_ok;
  logic             w_key_load;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_hs;
  logic [7:0]       w_key_next;
  logic [7:0]       w_result;
  logic             w_invalid;
  logic             w_dec;

  mod_p_addsub #(
    .P_MOD_P (P_MOD)
  ) u_addsub (
    .i_data    (in_data),
    .i_key     (r_key),
    .i_dec     (w_dec),
    .o_result  (w_result),
    .o_invalid (w_invalid)
  );

  // Handshake qualifiers; out_ready feeds in_ready combinationally so the
  // output register can be refilled on the same edge it drains.
  always_comb begin
    w_key_ok   = (public_key != 8'd0) && ({1'b0, public_key} < LP_MOD);
    w_key_load = (r_state == WAIT_KEY) && pk_ready && w_key_ok;
    w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
    w_accept   = in_valid && w_in_ready;
    w_out_hs   = r_out_valid && out_ready;
    w_dec      = (r_mode == MODE_DEC);
  end

  // Key value that applies to the character after the one being accepted.
  always_comb begin
`ifdef KEY_ROTATE_EN
    w_key_next = next_rot_key(r_key);
`else
    w_key_next = r_key;
`endif
  end

  // Next-state logic: key load, message run, drain of the final output.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_KEY: begin
        if (w_key_load) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = WAIT_KEY;
        end
      end
      RUN: begin
        if (w_accept && in_last) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (w_out_hs) begin
          w_state_nxt = WAIT_KEY;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = WAIT_KEY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_KEY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Key/mode register: loaded once per message, cleared after the final
  // output so a key is never reused for a second message.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= 8'd0;
      r_mode <= MODE_ENC;
    end else if (w_key_load) begin
      r_key  <= public_key;
      r_mode <= mode;
    end else if ((r_state == DRAIN) && w_out_hs) begin
      r_key  <= 8'd0;
      r_mode <= r_mode;
    end else if (w_accept) begin
      r_key  <= w_key_next;
      r_mode <= r_mode;
    end else begin
      r_key  <= r_key;
      r_mode <= r_mode;
    end
  end

  // Saturating count of characters accepted since the last key load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_count <= '0;
    end else if (w_key_load) begin
      r_byte_count <= '0;
    end else if (w_accept && (r_byte_count != LP_CNT_MAX)) begin
      r_byte_count <= r_byte_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_byte_count <= r_byte_count;
    end
  end

  // One-deep output register; payload is frozen while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= NULL_CHAR;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err_char  <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_result;
      r_out_valid <= 1'b1;
      r_out_last  <= in_last;
      r_err_char  <= w_invalid;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Single-cycle flag for a key offered while waiting that is out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_key <= 1'b0;
    end else begin
      r_err_key <= (r_state == WAIT_KEY) && pk_ready && !w_key_ok;
    end
  end

  // Output port mapping.
  always_comb begin
    in_ready         = w_in_ready;
    out_data         = r_out_data;
    out_valid        = r_out_valid;
    out_last         = r_out_last;
    err_invalid_char = r_err_char;
    err_invalid_key  = r_err_key;
    busy             = (r_state != WAIT_KEY);
    byte_count       = r_byte_count;
  end

endmodule

// File: tb/tb_mod_p_stream_cipher.sv
// Directed self-checking bench for mod_p_stream_cipher (both KEY_ROTATE_EN
// builds: expected values that depend on key rotation are chosen via ROT).
module tb_mod_p_stream_cipher;

`ifdef KEY_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  public_key;
  logic        pk_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        err_invalid_char;
  logic        err_invalid_key;
  logic        busy;
  logic [15:0] byte_count;

  int n_chk;
  int n_pass;

  mod_p_stream_cipher #(
    .P_MOD (32'd227),
    .CNT_W (32'd16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .public_key       (public_key),
    .pk_ready         (pk_ready),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_ready        (out_ready),
    .err_invalid_char (err_invalid_char),
    .err_invalid_key  (err_invalid_key),
    .busy             (busy),
    .byte_count       (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k, input logic [1:0] m);
    public_key = k;
    mode       = m;
    pk_ready   = 1'b1;
    tick();
    pk_ready   = 1'b0;
  endtask

  // Offer one character, confirm it will be taken, and clock it in.
  task automatic push(input logic [7:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    #1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; mode = 2'b00; public_key = 8'd0; pk_ready = 1'b0;
    in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, byte_count}, 32'd0);
    check("rst_err_key", {31'd0, err_invalid_key}, 32'd0);
    check("rst_err_char", {31'd0, err_invalid_char}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // Encrypt with key 50, including the wrap past 227.
    load_key(8'd50, 2'b00);
    check("enc_busy", {31'd0, busy}, 32'd1);
    check("enc_valid_pre", {31'd0, out_valid}, 32'd0);
    push(8'd65, 1'b0);
    check("enc_valid_lat1", {31'd0, out_valid}, 32'd1);
    check("enc_65", {24'd0, out_data}, 32'd115);
    check("enc_cnt1", {16'd0, byte_count}, 32'd1);
    push(8'd200, 1'b0);
    check("enc_200_wrap", {24'd0, out_data}, ROT ? 32'd24 : 32'd23);
    check("enc_cnt2", {16'd0, byte_count}, 32'd2);
    push(8'd0, 1'b1);
    check("enc_last_data", {24'd0, out_data}, ROT ? 32'd52 : 32'd50);
    check("enc_out_last", {31'd0, out_last}, 32'd1);
    check("drain_in_ready", {31'd0, in_ready}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    tick();
    check("drain_done_busy", {31'd0, busy}, 32'd0);
    check("drain_done_valid", {31'd0, out_valid}, 32'd0);

    // Decrypt with key 50.
    load_key(8'd50, 2'b01);
    push(8'd23, 1'b0);
    check("dec_23", {24'd0, out_data}, 32'd200);
    push(8'd115, 1'b0);
    check("dec_115", {24'd0, out_data}, ROT ? 32'd64 : 32'd65);
    push(8'd50, 1'b1);
    check("dec_50", {24'd0, out_data}, ROT ? 32'd225 : 32'd0);
    tick();

    // Invalid character, then a normal one with the flag clear.
    load_key(8'd10, 2'b00);
    push(8'd230, 1'b0);
    check("inv_data", {24'd0, out_data}, 32'd0);
    check("inv_flag", {31'd0, err_invalid_char}, 32'd1);
    check("inv_cnt", {16'd0, byte_count}, 32'd1);
    push(8'd5, 1'b1);
    check("inv_next_data", {24'd0, out_data}, ROT ? 32'd16 : 32'd15);
    check("inv_next_flag", {31'd0, err_invalid_char}, 32'd0);
    tick();

    // Unassigned mode code behaves as encrypt.
    load_key(8'd5, 2'b11);
    push(8'd7, 1'b1);
    check("mode3_enc", {24'd0, out_data}, 32'd12);
    tick();

    // Out-of-range keys are rejected with a one-cycle pulse.
    load_key(8'd0, 2'b00);
    check("key0_err", {31'd0, err_invalid_key}, 32'd1);
    check("key0_busy", {31'd0, busy}, 32'd0);
    tick();
    check("key_err_pulse_end", {31'd0, err_invalid_key}, 32'd0);
    load_key(8'd227, 2'b00);
    check("key227_err", {31'd0, err_invalid_key}, 32'd1);
    check("key227_busy", {31'd0, busy}, 32'd0);
    load_key(8'd1, 2'b00);
    check("key1_busy", {31'd0, busy}, 32'd1);
    check("key1_no_err", {31'd0, err_invalid_key}, 32'd0);

    // Backpressure with a stray key strobe during RUN, then full throughput.
    out_ready = 1'b0;
    push(8'd10, 1'b0);
    in_valid = 1'b1; in_data = 8'd20; in_last = 1'b0;
    #1;
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_data", {24'd0, out_data}, 32'd11);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_hold1", {24'd0, out_data}, 32'd11);
    check("bp_cnt_hold", {16'd0, byte_count}, 32'd1);
    public_key = 8'd100; pk_ready = 1'b1;
    tick();
    pk_ready = 1'b0;
    check("bp_hold2", {24'd0, out_data}, 32'd11);
    check("bp_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bb_valid1", {31'd0, out_valid}, 32'd1);
    check("bb_data1", {24'd0, out_data}, ROT ? 32'd22 : 32'd21);
    check("bb_cnt2", {16'd0, byte_count}, 32'd2);
    in_data = 8'd30; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("bb_valid2", {31'd0, out_valid}, 32'd1);
    check("bb_data2", {24'd0, out_data}, ROT ? 32'd33 : 32'd31);
    check("bb_last", {31'd0, out_last}, 32'd1);
    check("bb_cnt3", {16'd0, byte_count}, 32'd3);
    check("bb_drain_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("bb_wait_key", {31'd0, busy}, 32'd0);

    // Key 226 (wraps to 1 when rotating), then reset mid-message.
    load_key(8'd226, 2'b00);
    push(8'd0, 1'b0);
    check("rot_first", {24'd0, out_data}, 32'd226);
    push(8'd0, 1'b0);
    check("rot_second", {24'd0, out_data}, ROT ? 32'd1 : 32'd226);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cnt", {16'd0, byte_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
